// File: rtl/axil2apb_pkg.sv
// axil2apb shared types: FSM state encoding and AXI response codes.
// Imported by the bridge; the interfaces carry no package types.
package axil2apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WRESP,
    ST_RRESP
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [3:0] STRB_FULL       = 4'hF;

endpackage

// File: rtl/axil2apb_if.sv
// Bus bundles for the bridge: AXI4-Lite (bridge is slave)
// and APB3 (bridge is master).
interface axil_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );
endinterface

interface apb_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/axil2apb.sv
// AXI4-Lite slave to APB3 master bridge, one APB transfer at a time,
// with per-access timeout so a hung APB slave cannot stall AXI.
module axil2apb
  import axil2apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic   clk,
  input  logic   rstn,
  axil_if.slave  axil,
  apb_if.master  apb
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] T_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e        state_q, state_d;
  logic          aw_full_q, aw_full_d;
  logic          w_full_q, w_full_d;
  logic          ar_full_q, ar_full_d;
  logic [31:0]   aw_addr_q, aw_addr_d;
  logic [31:0]   w_data_q, w_data_d;
  logic [3:0]    w_strb_q, w_strb_d;
  logic [31:0]   ar_addr_q, ar_addr_d;
  logic          last_wr_q, last_wr_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic          pwrite_q, pwrite_d;
  logic [1:0]    resp_q, resp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic aw_hs, w_hs, ar_hs;
  logic aw_now, w_now, ar_now;
  logic [31:0] aw_addr_v, w_data_v, ar_addr_v;
  logic [3:0]  w_strb_v;
  logic pick_wr, done, free_wr, free_rd;

  assign axil.awready = rstn & ~aw_full_q;
  assign axil.wready  = rstn & ~w_full_q;
  assign axil.arready = rstn & ~ar_full_q;

  assign aw_hs = axil.awvalid & axil.awready;
  assign w_hs  = axil.wvalid & axil.wready;
  assign ar_hs = axil.arvalid & axil.arready;

  // A channel counts as held in the cycle it is accepted,
  // so a zero-wait transfer reaches SETUP one cycle later.
  assign aw_now = aw_full_q | aw_hs;
  assign w_now  = w_full_q | w_hs;
  assign ar_now = ar_full_q | ar_hs;

  assign aw_addr_v = aw_full_q ? aw_addr_q : axil.awaddr;
  assign w_data_v  = w_full_q ? w_data_q : axil.wdata;
  assign w_strb_v  = w_full_q ? w_strb_q : axil.wstrb;
  assign ar_addr_v = ar_full_q ? ar_addr_q : axil.araddr;

  // Next state, hold bookkeeping, arbitration and APB result capture
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    aw_addr_d = aw_hs ? axil.awaddr : aw_addr_q;
    w_data_d  = w_hs ? axil.wdata : w_data_q;
    w_strb_d  = w_hs ? axil.wstrb : w_strb_q;
    ar_addr_d = ar_hs ? axil.araddr : ar_addr_q;
    pick_wr   = 1'b0;
    done      = 1'b0;
    free_wr   = 1'b0;
    free_rd   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if ((aw_now & w_now) | ar_now) begin
          pick_wr = aw_now & w_now & (~ar_now | ~last_wr_q);
          if (aw_now & w_now & ar_now) last_wr_d = pick_wr;
          paddr_d  = pick_wr ? aw_addr_v : ar_addr_v;
          pwdata_d = pick_wr ? w_data_v : pwdata_q;
          pwrite_d = pick_wr;
          cnt_d    = '0;
          if (pick_wr && w_strb_v != STRB_FULL) begin
            free_wr = 1'b1;
            resp_d  = AXI_RESP_SLVERR;
            state_d = ST_WRESP;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (apb.pready) begin
          done    = 1'b1;
          resp_d  = apb.pslverr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          rdata_d = pwrite_q ? '0 : apb.prdata;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == T_LAST) begin
          done    = 1'b1;
          resp_d  = AXI_RESP_SLVERR;
          rdata_d = '0;
        end
        if (done) begin
          free_wr = pwrite_q;
          free_rd = ~pwrite_q;
          state_d = pwrite_q ? ST_WRESP : ST_RRESP;
        end
      end
      ST_WRESP: if (axil.bready) state_d = ST_IDLE;
      ST_RRESP: if (axil.rready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    aw_full_d = aw_now & ~free_wr;
    w_full_d  = w_now & ~free_wr;
    ar_full_d = ar_now & ~free_rd;
  end

  // State and hold registers; reset empties holds and aborts any transfer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
      last_wr_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      resp_q    <= AXI_RESP_OKAY;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      ar_full_q <= ar_full_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_addr_q <= ar_addr_d;
      last_wr_q <= last_wr_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign apb.psel    = (state_q == ST_SETUP) | (state_q == ST_ACCESS);
  assign apb.penable = (state_q == ST_ACCESS);
  assign apb.pwrite  = pwrite_q & apb.psel;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

  assign axil.bvalid = (state_q == ST_WRESP);
  assign axil.bresp  = axil.bvalid ? resp_q : AXI_RESP_OKAY;
  assign axil.rvalid = (state_q == ST_RRESP);
  assign axil.rresp  = axil.rvalid ? resp_q : AXI_RESP_OKAY;
  assign axil.rdata  = axil.rvalid ? rdata_q : '0;

endmodule
